// File: rtl/axi_mem_slave_pkg.sv
// Shared AXI definitions for the memory responder: burst/response encodings,
// burst length type and the channel state encodings.
package axi_mem_slave_pkg;

  localparam int AXI_BURST_MAX = 256;

  typedef logic [$clog2(AXI_BURST_MAX)-1:0] len_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_err_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP} r_state_t;

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// Next word index for a burst beat (FIXED/INCR, plus WRAP when
// AXI_MEM_SLAVE_WRAP_EN is defined). Purely combinational.
module axi_burst_addr_gen
  import axi_mem_slave_pkg::*;
#(
  parameter int IDX_W = 29
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       burst,
`ifdef AXI_MEM_SLAVE_WRAP_EN
  input  len_t             len,
`endif
  output logic [IDX_W-1:0] next_idx
);

`ifdef AXI_MEM_SLAVE_WRAP_EN
  // Legal wrap lengths are 2^n-1, so len itself is the in-block offset mask.
  logic [IDX_W-1:0] wrap_mask;
  assign wrap_mask = IDX_W'(len);
`endif

  always_comb begin
    next_idx = idx;
    case (burst)
      BURST_INCR: next_idx = idx + IDX_W'(1);
`ifdef AXI_MEM_SLAVE_WRAP_EN
      BURST_WRAP: next_idx = (idx & ~wrap_mask) | ((idx + IDX_W'(1)) & wrap_mask);
`endif
      default:    next_idx = idx;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder with independent read/write channels, one burst in
// flight per direction. Define AXI_MEM_SLAVE_WRAP_EN to accept WRAP bursts.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int RD_GAP    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = ADDR_W - LSB;
  localparam int MI_W  = $clog2(MEM_DEPTH);
  localparam int GAP_W = 16;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic resp_err_t req_resp(input logic [IDX_W-1:0] idx, input len_t len,
                                         input logic [1:0] burst);
    logic bad;
    bad = !(burst == BURST_FIXED || burst == BURST_INCR);
`ifdef AXI_MEM_SLAVE_WRAP_EN
    if (burst == BURST_WRAP)
      bad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`endif
    if (bad) return RESP_SLVERR;
    if ({1'b0, idx} + (IDX_W+1)'(len) >= (IDX_W+1)'(MEM_DEPTH)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_awaddr[LSB-1:0], s_araddr[LSB-1:0]};

  // ---------------- write channel ----------------
  w_state_t         w_state, w_next;
  logic [IDX_W-1:0] aw_idx, w_idx, w_idx_nxt;
  len_t             w_len, w_cnt;
  logic [1:0]       w_burst;
  resp_err_t        aw_resp, w_resp;
  logic             w_wlast_err;
  logic             aw_hs, w_hs, b_hs, w_last_beat;

  assign aw_idx      = s_awaddr[ADDR_W-1:LSB];
  assign aw_resp     = req_resp(aw_idx, s_awlen, s_awburst);
  assign aw_hs       = s_awvalid & s_awready;
  assign w_hs        = s_wvalid & s_wready;
  assign b_hs        = s_bvalid & s_bready;
  assign w_last_beat = (w_cnt == w_len);

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_w_addr (
    .idx      (w_idx),
    .burst    (w_burst),
`ifdef AXI_MEM_SLAVE_WRAP_EN
    .len      (w_len),
`endif
    .next_idx (w_idx_nxt)
  );

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      s_awready   <= 1'b0;
      s_wready    <= 1'b0;
      s_bvalid    <= 1'b0;
      s_bresp     <= 2'b00;
      w_cnt       <= '0;
      w_wlast_err <= 1'b0;
    end else begin
      w_state   <= w_next;
      s_awready <= (w_next == W_IDLE);
      s_wready  <= (w_next == W_DATA);
      if (aw_hs) begin
        w_cnt       <= '0;
        w_wlast_err <= 1'b0;
      end else if (w_hs) begin
        w_cnt <= w_cnt + len_t'(1);
        if (!w_last_beat && s_wlast) w_wlast_err <= 1'b1;
      end
      // Burst length comes from AWLEN; WLAST placement only affects the response.
      if (w_hs && w_last_beat) begin
        s_bvalid <= 1'b1;
        if (w_resp != RESP_OKAY)          s_bresp <= w_resp;
        else if (w_wlast_err || !s_wlast) s_bresp <= RESP_SLVERR;
        else                              s_bresp <= RESP_OKAY;
      end else if (b_hs) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_idx   <= aw_idx;
      w_len   <= s_awlen;
      w_burst <= s_awburst;
      w_resp  <= aw_resp;
    end else if (w_hs) begin
      w_idx <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_resp == RESP_OKAY) begin
      for (int b = 0; b < BYTES; b++)
        if (s_wstrb[b]) mem[w_idx[MI_W-1:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t         r_state, r_next;
  logic [IDX_W-1:0] ar_idx, r_idx, r_idx_nxt;
  len_t             r_len, r_cnt, r_ld_cnt, r_ld_len;
  logic [1:0]       r_burst;
  resp_err_t        ar_resp, r_resp, r_ld_resp;
  logic [MI_W-1:0]  r_ld_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             ar_hs, r_hs, r_last_beat, gap_done, r_load;

  assign ar_idx      = s_araddr[ADDR_W-1:LSB];
  assign ar_resp     = req_resp(ar_idx, s_arlen, s_arburst);
  assign ar_hs       = s_arvalid & s_arready;
  assign r_hs        = s_rvalid & s_rready;
  assign r_last_beat = (r_cnt == r_len);
  assign gap_done    = (gap_cnt == GAP_W'(RD_GAP - 1));

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_r_addr (
    .idx      (r_idx),
    .burst    (r_burst),
`ifdef AXI_MEM_SLAVE_WRAP_EN
    .len      (r_len),
`endif
    .next_idx (r_idx_nxt)
  );

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs) begin
                 if (r_last_beat)     r_next = R_IDLE;
                 else if (RD_GAP != 0) r_next = R_GAP;
               end
      R_GAP:   if (gap_done) r_next = R_DATA;
      default: r_next = R_IDLE;
    endcase
  end

  // Beat source select: first beat from AR, later beats from the burst state.
  // Loading reads memory at the same edge a write may commit, so reads see old data.
  always_comb begin
    r_load    = 1'b0;
    r_ld_idx  = r_idx_nxt[MI_W-1:0];
    r_ld_cnt  = r_cnt + len_t'(1);
    r_ld_len  = r_len;
    r_ld_resp = r_resp;
    if (ar_hs) begin
      r_load    = 1'b1;
      r_ld_idx  = ar_idx[MI_W-1:0];
      r_ld_cnt  = '0;
      r_ld_len  = s_arlen;
      r_ld_resp = ar_resp;
    end else if (r_state == R_GAP) begin
      r_load   = gap_done;
      r_ld_idx = r_idx[MI_W-1:0];
      r_ld_cnt = r_cnt;
    end else if (r_hs && !r_last_beat && RD_GAP == 0) begin
      r_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
      s_rlast   <= 1'b0;
      r_cnt     <= '0;
      gap_cnt   <= '0;
    end else begin
      r_state   <= r_next;
      s_arready <= (r_next == R_IDLE);
      gap_cnt   <= (r_state == R_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (ar_hs)                    r_cnt <= '0;
      else if (r_hs && !r_last_beat) r_cnt <= r_cnt + len_t'(1);
      if (r_load) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (r_ld_resp == RESP_OKAY) ? mem[r_ld_idx] : '0;
        s_rresp  <= r_ld_resp;
        s_rlast  <= (r_ld_cnt == r_ld_len);
      end else if (r_hs) begin
        s_rvalid <= 1'b0;
        s_rlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_idx   <= ar_idx;
      r_len   <= s_arlen;
      r_burst <= s_arburst;
      r_resp  <= ar_resp;
    end else if (r_hs && !r_last_beat) begin
      r_idx <= r_idx_nxt;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave (default build: WRAP disabled, RD_GAP=0).
module tb_axi_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic [7:0]  s_awlen = '0;
  logic [1:0]  s_awburst = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [1:0]  s_arburst = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1'b0;

  always #5 clk = ~clk;

  axi_mem_slave #(.DATA_W(64), .ADDR_W(32), .MEM_DEPTH(1024), .RD_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          wl;
    logic [1:0]  exp_b;
    logic        do_wr;
    logic [31:0] rd_addr;
    logic [1:0]  rd_burst;
    logic [7:0]  rd_len;
  } vec_t;

  beat_t       rq[$];
  logic [63:0] ref_mem [1024];
  vec_t        tbl [15];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference response: only FIXED/INCR legal here, range by start index + len.
  function automatic logic [1:0] m_resp(input logic [31:0] addr, input logic [7:0] len,
                                        input logic [1:0] burst);
    if (!(burst == 2'b00 || burst == 2'b01)) return 2'b10;
    if (int'(addr >> 3) + int'(len) >= 1024) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int m_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
    return (burst == 2'b00) ? int'(addr >> 3) : int'(addr >> 3) + b;
  endfunction

  // Scoreboard: every R handshake pops one expected beat; stalled beats must hold.
  logic        held_v = 1'b0;
  logic [66:0] held;
  beat_t       mon_e;
  always @(negedge clk) begin
    if (!rst_n || !s_rvalid) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("r_stable", {s_rdata, s_rresp, s_rlast}, held);
      if (s_rready) begin
        held_v = 1'b0;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_extra: unexpected beat %h", s_rdata);
        end else begin
          mon_e = rq.pop_front();
          check("r_beat", {s_rdata, s_rresp, s_rlast}, {mon_e.data, mon_e.resp, mon_e.last});
        end
      end else begin
        held_v = 1'b1;
        held   = {s_rdata, s_rresp, s_rlast};
      end
    end
  end

  task automatic wait_rdy(input int which, input string nm);
    int   to = 0;
    logic v;
    do begin
      @(negedge clk);
      to++;
      case (which)
        0:       v = s_awready;
        1:       v = s_wready;
        2:       v = s_bvalid;
        default: v = s_arready;
      endcase
    end while (!v && to < 100);
    if (!v) begin
      checks++; errors++;
      $display("FAIL %s: timeout, signal still 0 after %0d cycles", nm, to);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int wl, input logic [7:0] strb, input logic [63:0] pat,
                          input logic inc, input logic [1:0] exp_b);
    logic ok;
    int   idx;
    ok = (m_resp(addr, len, burst) == 2'b00);
    s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
    wait_rdy(0, "aw_ready");
    @(posedge clk); #1 s_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wdata  = inc ? pat + 64'(b + 1) * 64'h11 : pat;
      s_wstrb  = strb;
      s_wlast  = (b == wl);
      s_wvalid = 1'b1;
      wait_rdy(1, "w_ready");
      @(posedge clk); #1;
      if (ok) begin
        idx = m_idx(addr, burst, b);
        for (int k = 0; k < 8; k++)
          if (strb[k]) ref_mem[idx][k*8 +: 8] = s_wdata[k*8 +: 8];
      end
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("b_timing", s_bvalid, 1'b1);
    s_bready = 1'b1;
    wait_rdy(2, "b_valid");
    check("bresp", s_bresp, exp_b);
    @(posedge clk); #1 s_bready = 1'b0;
    check("b_clear", s_bvalid, 1'b0);
  endtask

  task automatic drain(input logic toggle, input string nm);
    int to = 0;
    while (rq.size() != 0 && to < 400) begin
      @(posedge clk); #1;
      if (toggle) s_rready = ~s_rready;
      to++;
    end
    if (rq.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: %0d beats never arrived", nm, rq.size());
      rq.delete();
    end
    s_rready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic toggle);
    logic [1:0] r;
    beat_t      e;
    r = m_resp(addr, len, burst);
    for (int b = 0; b <= int'(len); b++) begin
      e.data = (r == 2'b00) ? ref_mem[m_idx(addr, burst, b)] : 64'h0;
      e.resp = r;
      e.last = (b == int'(len));
      rq.push_back(e);
    end
    s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
    s_rready = !toggle;
    wait_rdy(3, "ar_ready");
    @(posedge clk); #1 s_arvalid = 1'b0;
    check("r_first", s_rvalid, 1'b1);
    drain(toggle, "r_drain");
    check("r_done", s_rvalid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat_t e;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 64'h0;

    //          addr      len   burst wl  exp_b do_wr rd_addr   rd_b  rd_len
    tbl[0]  = '{32'h100,  8'd3, 2'd1, 3,  2'd0, 1'b1, 32'h100,  2'd1, 8'd3};
    tbl[1]  = '{32'h000,  8'd3, 2'd1, 3,  2'd0, 1'b1, 32'h000,  2'd1, 8'd3};
    tbl[2]  = '{32'h1FF8, 8'd0, 2'd1, 0,  2'd0, 1'b1, 32'h1FF8, 2'd1, 8'd0};
    tbl[3]  = '{32'h1FF8, 8'd1, 2'd1, 1,  2'd3, 1'b1, 32'h1FF8, 2'd1, 8'd1};
    tbl[4]  = '{32'h1FF8, 8'd0, 2'd1, 0,  2'd0, 1'b0, 32'h1FF8, 2'd1, 8'd0};
    tbl[5]  = '{32'h018,  8'd3, 2'd2, 3,  2'd2, 1'b1, 32'h000,  2'd1, 8'd3};
    tbl[6]  = '{32'h600,  8'd3, 2'd1, 3,  2'd0, 1'b1, 32'h600,  2'd1, 8'd3};
    tbl[7]  = '{32'h600,  8'd3, 2'd3, 3,  2'd2, 1'b1, 32'h600,  2'd1, 8'd3};
    tbl[8]  = '{32'h400,  8'd3, 2'd1, 1,  2'd2, 1'b1, 32'h400,  2'd1, 8'd3};
    tbl[9]  = '{32'h500,  8'd2, 2'd1, 99, 2'd2, 1'b1, 32'h500,  2'd1, 8'd2};
    tbl[10] = '{32'h300,  8'd3, 2'd0, 3,  2'd0, 1'b1, 32'h300,  2'd0, 8'd3};
    tbl[11] = '{32'h705,  8'd1, 2'd1, 1,  2'd0, 1'b1, 32'h700,  2'd1, 8'd1};
    tbl[12] = '{32'h200,  8'd0, 2'd1, 0,  2'd0, 1'b1, 32'h200,  2'd1, 8'd0};
    tbl[13] = '{32'h018,  8'd3, 2'd2, 3,  2'd0, 1'b0, 32'h018,  2'd2, 8'd3};
    tbl[14] = '{32'h600,  8'd1, 2'd3, 1,  2'd0, 1'b0, 32'h600,  2'd3, 8'd1};

    // Reset state and first ready cycle
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
                          s_rresp, s_rlast, s_rdata}, '0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_ready_hold", {s_awready, s_arready}, 2'b00);
    @(posedge clk); #1;
    check("rst_ready_rise", {s_awready, s_arready}, 2'b11);

    for (int v = 0; v < 15; v++) begin
      if (tbl[v].do_wr)
        do_write(tbl[v].addr, tbl[v].len, tbl[v].burst, tbl[v].wl, 8'hFF,
                 {8'(v), 56'h0}, 1'b1, tbl[v].exp_b);
      do_read(tbl[v].rd_addr, tbl[v].rd_len, tbl[v].rd_burst, 1'b0);
    end

    // Partial strobe over an all-ones word
    do_write(32'h0, 8'd0, 2'd1, 0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0);
    do_write(32'h0, 8'd0, 2'd1, 0, 8'h0F, 64'h0, 1'b0, 2'd0);
    do_read(32'h0, 8'd0, 2'd1, 1'b0);

    // Backpressure: rready alternates during an 8-beat read
    do_write(32'h800, 8'd7, 2'd1, 7, 8'hFF, 64'hA5A5_0000_0000_0000, 1'b1, 2'd0);
    do_read(32'h800, 8'd7, 2'd1, 1'b1);

    // Same-cycle read and write of one word: read returns the old value
    do_write(32'h900, 8'd0, 2'd1, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 2'd0);
    s_awaddr = 32'h900; s_awlen = 8'd0; s_awburst = 2'd1; s_awvalid = 1'b1;
    wait_rdy(0, "cc_aw_ready");
    @(posedge clk); #1 s_awvalid = 1'b0;
    e.data = ref_mem[32'h900 >> 3]; e.resp = 2'b00; e.last = 1'b1;
    rq.push_back(e);
    s_wdata = 64'hDEAD_BEEF_CAFE_F00D; s_wstrb = 8'hFF; s_wlast = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h900; s_arlen = 8'd0; s_arburst = 2'd1; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    check("cc_both_ready", {s_wready, s_arready}, 2'b11);
    @(posedge clk); #1;
    s_wvalid = 1'b0; s_wlast = 1'b0; s_arvalid = 1'b0;
    ref_mem[32'h900 >> 3] = 64'hDEAD_BEEF_CAFE_F00D;
    check("cc_b_timing", s_bvalid, 1'b1);
    check("cc_rvalid", s_rvalid, 1'b1);
    s_bready = 1'b1;
    @(negedge clk);
    check("cc_bresp", s_bresp, 2'b00);
    @(posedge clk); #1 s_bready = 1'b0;
    s_rready = 1'b1;
    drain(1'b0, "cc_drain");
    do_read(32'h900, 8'd0, 2'd1, 1'b0);

    // Reset pulsed mid-read while the beat is stalled
    s_araddr = 32'h800; s_arlen = 8'd7; s_arburst = 2'd1; s_arvalid = 1'b1; s_rready = 1'b0;
    wait_rdy(3, "rst_ar_ready");
    @(posedge clk); #1 s_arvalid = 1'b0;
    check("rst_pre_rvalid", s_rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rvalid_async", s_rvalid, 1'b0);
    check("rst_arready_low", s_arready, 1'b0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    #1 check("rst_arready_hold", s_arready, 1'b0);
    @(posedge clk); #1;
    check("rst_arready_rise", {s_arready, s_awready}, 2'b11);
    do_read(32'h800, 8'd7, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
